// File: rtl/uart_pkg.sv
// Shared encodings and elaboration helpers for the UART transmitter family.
package uart_pkg;

  typedef enum logic [1:0] {
    UART_PAR_NONE = 2'd0,
    UART_PAR_ODD  = 2'd1,
    UART_PAR_EVEN = 2'd2,
    UART_PAR_MARK = 2'd3
  } uart_par_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic int unsigned uart_cnt_width(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty/level.
module uart_sync_fifo #(
  parameter int unsigned P_WIDTH = 8,
  parameter int unsigned P_DEPTH = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_push,
  input  logic [P_WIDTH-1:0]             i_data,
  input  logic                           i_pop,
  output logic [P_WIDTH-1:0]             o_data,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(P_DEPTH+1)-1:0]   o_level
);

  localparam int unsigned AW = $clog2(P_DEPTH);
  localparam int unsigned LW = $clog2(P_DEPTH + 1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(P_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [P_WIDTH-1:0] mem_q [P_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]      level_q, level_d;
  logic               full_q, empty_q;
  logic               do_push, do_pop;

  assign do_push = i_push & ~full_q;
  assign do_pop  = i_pop & ~empty_q;

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LVL_ONE;
    end else if (do_pop && !do_push) begin
      level_d = level_q - LVL_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q <= level_d;
      full_q  <= (level_d == LVL_FULL);
      empty_q <= (level_d == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_level = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: baud-timed framing, per-frame parity/stop config,
// back-to-back frames from the FIFO and idle line-break generation.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned P_SYSTEM_CLK      = 50_000_000,
  parameter int unsigned P_UART_BAUDRATE   = 115200,
  parameter int unsigned P_UART_DATA_WIDTH = 8,
  parameter int unsigned P_FIFO_DEPTH      = 16
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [P_UART_DATA_WIDTH-1:0]        i_user_tx_data,
  input  logic                                i_user_tx_valid,
  output logic                                o_user_tx_ready,
  input  logic [1:0]                          i_cfg_parity,
  input  logic                                i_cfg_stop2,
  input  logic                                i_break,
  output logic                                o_uart_tx,
  output logic                                o_busy,
  output logic [$clog2(P_FIFO_DEPTH+1)-1:0]   o_fifo_level
);

  localparam int unsigned DW  = P_UART_DATA_WIDTH;
  localparam int unsigned DIV = uart_div(P_SYSTEM_CLK, P_UART_BAUDRATE);
  localparam int unsigned CW  = uart_cnt_width(DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [3:0]    BIT_LAST  = 4'(DW - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [DW-1:0] shift_q, shift_d;
  logic          par_en_q, par_en_d;
  logic          par_bit_q, par_bit_d;
  logic          stop2_q, stop2_d;
  logic          tx_q, tx_d;

  logic          fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          baud_end, can_start, load, new_par_bit;

  uart_sync_fifo #(
    .P_WIDTH (DW),
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_user_tx_valid),
    .i_data  (i_user_tx_data),
    .i_pop   (fifo_pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_fifo_level)
  );

  assign baud_end  = (baud_q == BAUD_LAST);
  assign can_start = ~fifo_empty & ~i_break;

  always_comb begin
    case (uart_par_e'(i_cfg_parity))
      UART_PAR_ODD:  new_par_bit = ~^fifo_data;
      UART_PAR_EVEN: new_par_bit = ^fifo_data;
      default:       new_par_bit = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    load      = 1'b0;
    fifo_pop  = 1'b0;

    if (state_q == ST_IDLE) begin
      baud_d = '0;
    end else begin
      baud_d = baud_end ? '0 : baud_q + BAUD_ONE;
    end

    unique case (state_q)
      ST_IDLE: begin
        tx_d = ~i_break;
        // A low tx_q here means break was just released: give the line one high cycle first.
        if (can_start && tx_q) load = 1'b1;
      end
      ST_START: begin
        if (baud_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (baud_end) begin
          state_d = ST_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          if (stop2_q && bit_q == 4'd0) begin
            bit_d = 4'd1;
          end else begin
            bit_d = '0;
            if (can_start) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      fifo_pop  = 1'b1;
      shift_d   = fifo_data;
      par_en_d  = (uart_par_e'(i_cfg_parity) != UART_PAR_NONE);
      par_bit_d = new_par_bit;
      stop2_d   = i_cfg_stop2;
      bit_d     = '0;
      state_d   = ST_START;
      tx_d      = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
    end
  end

  assign o_uart_tx       = tx_q;
  assign o_busy          = (state_q != ST_IDLE);
  assign o_user_tx_ready = ~fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at DIV=10, depth 4: table vectors, hand-timed corner
// sequences and random bursts decoded against a frame-level reference model.
module tb_uart_tx_fifo;

  localparam int DIV = 10;
  localparam int DW  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_user_tx_data;
  logic       i_user_tx_valid;
  logic       o_user_tx_ready;
  logic [1:0] i_cfg_parity;
  logic       i_cfg_stop2;
  logic       i_break;
  logic       o_uart_tx;
  logic       o_busy;
  logic [2:0] o_fifo_level;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .P_SYSTEM_CLK      (50_000_000),
    .P_UART_BAUDRATE   (5_000_000),
    .P_UART_DATA_WIDTH (8),
    .P_FIFO_DEPTH      (4)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_user_tx_data  (i_user_tx_data),
    .i_user_tx_valid (i_user_tx_valid),
    .o_user_tx_ready (o_user_tx_ready),
    .i_cfg_parity    (i_cfg_parity),
    .i_cfg_stop2     (i_cfg_stop2),
    .i_break         (i_break),
    .o_uart_tx       (o_uart_tx),
    .o_busy          (o_busy),
    .o_fifo_level    (o_fifo_level)
  );

  typedef struct {
    logic [7:0] w;
    logic [1:0] par;
    logic       st2;
  } ent_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] par;
    logic       st2;
    logic       exp_par;
    int         len;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  bit   rec = 1'b0;
  logic line_q[$];
  ent_t exp_q[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (rec) line_q.push_back(o_uart_tx);
    if (o_busy) busy_cnt++;
  endtask

  // Reference frame: bit k of the result is the k-th line bit, start bit first.
  function automatic logic [15:0] frame_bits(input ent_t e, output int nb);
    logic [15:0] v;
    logic [7:0]  t;
    int          n;
    int          ones;
    logic        pb;
    v = '0;
    n = 1;
    for (int k = 0; k < DW; k++) begin
      t = e.w >> k;
      v = v | (16'(t[0]) << n);
      n++;
    end
    ones = $countones(e.w);
    if (e.par != 2'd0) begin
      if (e.par == 2'd1)      pb = ((ones % 2) == 0);
      else if (e.par == 2'd2) pb = ((ones % 2) == 1);
      else                    pb = 1'b1;
      v = v | (16'(pb) << n);
      n++;
    end
    v = v | (16'h1 << n);
    n++;
    if (e.st2) begin
      v = v | (16'h1 << n);
      n++;
    end
    nb = n;
    return v;
  endfunction

  task automatic push_word(input logic [7:0] w, input logic [1:0] p, input logic s2,
                           input int gapmax, output int acc_cyc);
    int   g;
    ent_t e;
    g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    repeat (g) step();
    i_user_tx_data  = w;
    i_user_tx_valid = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (o_user_tx_ready) begin
        acc_cyc = cyc;
        e.w = w; e.par = p; e.st2 = s2;
        exp_q.push_back(e);
        step();
        i_user_tx_valid = 1'b0;
        return;
      end
      step();
    end
    check("push_timeout", 1, 0);
    i_user_tx_valid = 1'b0;
    acc_cyc = -1;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while ((o_busy || o_fifo_level != 3'd0) && t < 3000) begin
      step();
      t++;
    end
    check({tag, "_idle"}, 32'(o_busy || o_fifo_level != 3'd0), 0);
  endtask

  // Decode recorded line samples at bit centres and match against exp_q.
  task automatic check_line(input string tag, output int gaps);
    int          i, prev_end, nb, frames, extra, idx;
    bit          trunc;
    logic [15:0] ev, gv;
    ent_t        e;
    i = 0; prev_end = 0; frames = 0; extra = 0; gaps = 0;
    while (i < line_q.size()) begin
      if (line_q[i] === 1'b0) begin
        if (exp_q.size() == 0) begin
          extra++;
          break;
        end
        e = exp_q.pop_front();
        ev = frame_bits(e, nb);
        gv = '0;
        trunc = 1'b0;
        for (int k = 0; k < nb; k++) begin
          idx = i + k * DIV + DIV / 2;
          if (idx < line_q.size()) gv = gv | (16'(line_q[idx]) << k);
          else trunc = 1'b1;
        end
        if (trunc) gv = ~ev;
        if (frames > 0 && i != prev_end) gaps++;
        check({tag, "_frame"}, 32'(gv), 32'(ev));
        frames++;
        i = i + nb * DIV;
        prev_end = i;
      end else begin
        i++;
      end
    end
    check({tag, "_extra"}, extra, 0);
    check({tag, "_missing"}, exp_q.size(), 0);
    exp_q.delete();
    line_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc, acc0, gaps, first_low, bad, nb, n;
    logic [15:0] ev, tmp;
    logic        expb;
    logic [1:0]  p;
    logic        s2;
    ent_t        e;

    vecs[0] = '{8'hA5, 2'd0, 1'b0, 1'b0, 100};
    vecs[1] = '{8'h07, 2'd1, 1'b0, 1'b0, 110};
    vecs[2] = '{8'h07, 2'd2, 1'b0, 1'b1, 110};
    vecs[3] = '{8'h07, 2'd2, 1'b1, 1'b1, 120};
    vecs[4] = '{8'h00, 2'd1, 1'b0, 1'b1, 110};
    vecs[5] = '{8'hFF, 2'd3, 1'b1, 1'b1, 120};
    vecs[6] = '{8'h3C, 2'd2, 1'b0, 1'b0, 110};
    vecs[7] = '{8'h5A, 2'd1, 1'b1, 1'b1, 120};

    rst_n = 1'b0;
    i_user_tx_data = '0;
    i_user_tx_valid = 1'b0;
    i_cfg_parity = 2'd0;
    i_cfg_stop2 = 1'b0;
    i_break = 1'b0;
    #12;
    check("reset_tx", o_uart_tx, 1);
    check("reset_ready", o_user_tx_ready, 1);
    check("reset_busy", o_busy, 0);
    check("reset_level", o_fifo_level, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    // Table vectors: exact waveform, latency, busy length, parity bit.
    foreach (vecs[v]) begin
      i_cfg_parity = vecs[v].par;
      i_cfg_stop2  = vecs[v].st2;
      line_q.delete();
      busy_cnt = 0;
      rec = 1'b1;
      push_word(vecs[v].data, vecs[v].par, vecs[v].st2, 0, acc);
      repeat (vecs[v].len + 10) step();
      rec = 1'b0;
      exp_q.delete();
      first_low = -1;
      for (int i = 0; i < line_q.size(); i++)
        if (line_q[i] === 1'b0 && first_low < 0) first_low = i;
      check("vec_latency", first_low, 1);
      e.w = vecs[v].data; e.par = vecs[v].par; e.st2 = vecs[v].st2;
      ev = frame_bits(e, nb);
      bad = 0;
      for (int i = 0; i < line_q.size(); i++) begin
        if (i >= 1 && i < 1 + nb * DIV) begin
          tmp = ev >> ((i - 1) / DIV);
          expb = tmp[0];
        end else begin
          expb = 1'b1;
        end
        if (line_q[i] !== expb) bad++;
      end
      check("vec_wave", bad, 0);
      check("vec_len", busy_cnt, vecs[v].len);
      if (vecs[v].par != 2'd0)
        check("vec_parity", 32'(line_q[1 + (1 + DW) * DIV + DIV / 2]), 32'(vecs[v].exp_par));
      line_q.delete();
    end

    // FIFO burst of 6 into depth 4.
    i_cfg_parity = 2'd0;
    i_cfg_stop2  = 1'b0;
    line_q.delete();
    rec = 1'b1;
    acc0 = cyc;
    for (int j = 0; j < 5; j++) begin
      push_word(8'(8'h30 + j), 2'd0, 1'b0, 0, acc);
      check("burst_accept", acc - acc0, j);
    end
    check("burst_ready_low", o_user_tx_ready, 0);
    check("burst_level4", o_fifo_level, 4);
    check("burst_busy", o_busy, 1);
    push_word(8'h35, 2'd0, 1'b0, 0, acc);
    check("burst_sixth_accept", acc - acc0, 102);
    wait_idle("burst");
    repeat (3) step();
    rec = 1'b0;
    check_line("burst", gaps);
    check("burst_gaps", gaps, 0);

    // Parity config changed while a frame is in flight.
    line_q.delete();
    rec = 1'b1;
    push_word(8'hC3, 2'd0, 1'b0, 0, acc);
    repeat (30) step();
    i_cfg_parity = 2'd2;
    push_word(8'h96, 2'd2, 1'b0, 0, acc);
    wait_idle("cfg");
    repeat (3) step();
    rec = 1'b0;
    check_line("cfg", gaps);
    check("cfg_gaps", gaps, 0);
    i_cfg_parity = 2'd0;

    // Line break while idle with a queued word.
    i_break = 1'b1;
    push_word(8'h5A, 2'd0, 1'b0, 0, acc);
    repeat (30) step();
    check("brk_line", o_uart_tx, 0);
    check("brk_level", o_fifo_level, 1);
    check("brk_busy", o_busy, 0);
    i_break = 1'b0;
    line_q.delete();
    rec = 1'b1;
    for (int t = 1; t <= 103; t++) begin
      step();
      if (t == 1)   check("brk_release_high", o_uart_tx, 1);
      if (t == 2)   check("brk_start", {o_uart_tx, o_busy}, 2'b01);
      if (t == 50)  i_break = 1'b1;
      if (t == 101) rec = 1'b0;
      if (t == 102) check("brk_frame_end", {o_uart_tx, o_busy}, 2'b10);
      if (t == 103) check("brk_reassert", o_uart_tx, 0);
    end
    check_line("brk", gaps);
    i_break = 1'b0;
    step();
    check("brk_final_high", o_uart_tx, 1);
    step();

    // Reset in the middle of a frame of zero bits.
    for (int j = 0; j < 3; j++) push_word(8'h00, 2'd0, 1'b0, 0, acc);
    repeat (40) step();
    check("rst_pre_line", {o_uart_tx, o_busy}, 2'b01);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", o_uart_tx, 1);
    check("rst_mid_ready", o_user_tx_ready, 1);
    check("rst_mid_busy", o_busy, 0);
    check("rst_mid_level", o_fifo_level, 0);
    step();
    step();
    rst_n = 1'b1;
    exp_q.delete();
    line_q.delete();
    rec = 1'b1;
    repeat (150) step();
    rec = 1'b0;
    check_line("post_rst", gaps);
    check("post_rst_level", o_fifo_level, 0);

    // Random bursts, config held per burst.
    for (int b = 0; b < 6; b++) begin
      p  = 2'($urandom_range(3, 0));
      s2 = 1'($urandom_range(1, 0));
      i_cfg_parity = p;
      i_cfg_stop2  = s2;
      line_q.delete();
      rec = 1'b1;
      n = int'($urandom_range(8, 1));
      for (int j = 0; j < n; j++) push_word(8'($urandom), p, s2, 120, acc);
      wait_idle("rand");
      repeat (3) step();
      rec = 1'b0;
      check_line("rand", gaps);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
